// File: rtl/booth_pkg.sv
// Shared constants, state encoding and saturation helper for the
// Booth product accumulator.
package booth_pkg;

    localparam int PROD_W = 16;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // Clamp a sign-extended sum to the signed range of a width-bit word (width <= 63).
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] sum,
                                                     input int width);
        logic signed [63:0] max_pos;
        logic signed [63:0] min_neg;
        max_pos = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_neg = -max_pos - 64'sd1;
        if (sum > max_pos) begin
            return max_pos;
        end else if (sum < min_neg) begin
            return min_neg;
        end
        return sum;
    endfunction

endpackage

// File: rtl/booth_product_accumulator_sat_adder.sv
// Signed W-bit accumulator plus sign-extended 16-bit product, with
// overflow detect and optional clamp to the W-bit signed range.
module sat_adder
    import booth_pkg::*;
#(
    parameter int W        = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic [W-1:0]      a,
    input  logic [PROD_W-1:0] b,
    output logic [W-1:0]      sum,
    output logic              ovf
);

    logic signed [W:0] sum_wide;

    always_comb begin
        sum_wide = $signed({a[W-1], a}) + $signed({{(W + 1 - PROD_W){b[PROD_W-1]}}, b});
        // Top two bits disagree exactly when the sum leaves the W-bit signed range.
        ovf = sum_wide[W] ^ sum_wide[W-1];
        if (SATURATE && ovf) begin
            sum = W'(sat_clamp(64'(sum_wide), W));
        end else begin
            sum = sum_wide[W-1:0];
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates a frame of signed Booth products into a wide sum and
// hands each finished frame to the consumer over valid/ready.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256,
    parameter bit SATURATE  = 1'b1,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_clr,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_terms,
    output logic              out_overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_terms_q, out_terms_d;
    logic               out_overflow_q, out_overflow_d;

    logic               accept;
    logic               frame_end;
    logic [CNT_W-1:0]   count_inc;
    logic               ovf_base;
    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;

    // A clear or an empty accumulator makes this beat term 1 of a fresh frame.
    always_comb begin
        accept    = in_valid & in_ready;
        add_a     = (in_clr || (count_q == '0)) ? '0 : acc_q;
        count_inc = in_clr ? CNT_W'(1) : count_q + CNT_W'(1);
        ovf_base  = in_clr ? 1'b0 : ovf_q;
        frame_end = in_last || (count_inc == CNT_W'(MAX_TERMS));
    end

    sat_adder #(
        .W        (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_adder (
        .a   (add_a),
        .b   (prod_in),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_ACC;
            acc_q          <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_terms_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_terms_q    <= out_terms_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && frame_end) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_ACC);
    end

    always_comb begin
        acc_d          = acc_q;
        count_d        = count_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_terms_d    = out_terms_q;
        out_overflow_d = out_overflow_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d   = add_sum;
                    count_d = count_inc;
                    ovf_d   = ovf_base | add_ovf;
                    if (frame_end) begin
                        out_valid_d    = 1'b1;
                        out_data_d     = add_sum;
                        out_terms_d    = count_inc;
                        out_overflow_d = ovf_base | add_ovf;
                    end
                end else if (in_clr) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_terms    = out_terms_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: three lock-stepped instances
// (24-bit saturating, 16-bit saturating, 16-bit wrapping) against a scoreboard.
module tb_booth_product_accumulator;

    localparam int MAXT = 4;
    localparam int CW   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] prod_in = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_clr = 1'b0;
    logic        out_ready = 1'b0;

    logic          rdy24, rdy16s, rdy16w;
    logic          vld24, vld16s, vld16w;
    logic          ovf24, ovf16s, ovf16w;
    logic [23:0]   dat24;
    logic [15:0]   dat16s, dat16w;
    logic [CW-1:0] trm24, trm16s, trm16w;

    always #5 clk = ~clk;

    booth_product_accumulator #(.ACC_W(24), .MAX_TERMS(MAXT), .SATURATE(1'b1)) dut24 (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
        .in_clr(in_clr), .in_ready(rdy24), .out_data(dat24), .out_terms(trm24),
        .out_overflow(ovf24), .out_valid(vld24), .out_ready(out_ready));

    booth_product_accumulator #(.ACC_W(16), .MAX_TERMS(MAXT), .SATURATE(1'b1)) dut16s (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
        .in_clr(in_clr), .in_ready(rdy16s), .out_data(dat16s), .out_terms(trm16s),
        .out_overflow(ovf16s), .out_valid(vld16s), .out_ready(out_ready));

    booth_product_accumulator #(.ACC_W(16), .MAX_TERMS(MAXT), .SATURATE(1'b0)) dut16w (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
        .in_clr(in_clr), .in_ready(rdy16w), .out_data(dat16w), .out_terms(trm16w),
        .out_overflow(ovf16w), .out_valid(vld16w), .out_ready(out_ready));

    typedef struct {
        longint d[3];
        bit     o[3];
        int     terms;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc[3];
    bit     m_ovf[3];
    int     m_cnt;
    int     wid[3] = '{24, 16, 16};
    bit     sat[3] = '{1'b1, 1'b1, 1'b0};
    int     passed = 0;
    int     total  = 0;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_beat(input logic [15:0] p, input bit last, input bit clr);
        exp_t   e;
        longint base, s, lim, m;
        bit     ov;
        for (int i = 0; i < 3; i++) begin
            base = (clr || m_cnt == 0) ? 0 : m_acc[i];
            s    = base + longint'($signed(p));
            lim  = longint'(1) << (wid[i] - 1);
            ov   = (s > lim - 1) || (s < -lim);
            if (ov) begin
                if (sat[i]) begin
                    s = (s > 0) ? lim - 1 : -lim;
                end else begin
                    m = lim * 2;
                    s = s & (m - 1);
                    if (s >= lim) s = s - m;
                end
            end
            m_acc[i] = s;
            m_ovf[i] = (clr ? 1'b0 : m_ovf[i]) | ov;
        end
        m_cnt = clr ? 1 : m_cnt + 1;
        if (last || m_cnt == MAXT) begin
            e.d     = m_acc;
            e.o     = m_ovf;
            e.terms = m_cnt;
            exp_q.push_back(e);
            model_clear();
        end
    endtask

    task automatic beat(input logic [15:0] p, input bit v, input bit last, input bit clr);
        @(negedge clk);
        prod_in  = p;
        in_valid = v;
        in_last  = last;
        in_clr   = clr;
        if (rdy24) begin
            if (v) model_beat(p, last, clr);
            else if (clr) model_clear();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_clr   = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        total++;
        if ({vld24, dat24, trm24, ovf24, rdy24, vld16s, dat16s, trm16s, ovf16s, rdy16s,
             vld16w, dat16w, trm16w, ovf16w, rdy16w} !==
            {1'b0, 24'h0, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1,
             1'b0, 16'h0, 3'd0, 1'b0, 1'b1})
            $display("FAIL %s idle: v=%b d=%h t=%0d o=%b r=%b / v=%b d=%h r=%b / v=%b d=%h r=%b, want all zero and ready",
                     name, vld24, dat24, trm24, ovf24, rdy24, vld16s, dat16s, rdy16s, vld16w, dat16w, rdy16w);
        else passed++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic expect_result(input string name);
        exp_t        e;
        int          n;
        logic [63:0] v0, v1, v2;
        n = 0;
        @(negedge clk);
        while (!vld24 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!vld24) begin
            total++;
            $display("FAIL %s timeout: out_valid=%b after %0d cycles, want 1", name, vld24, n);
            return;
        end
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL %s unexpected: got frame d=%h t=%0d, want no frame", name, dat24, trm24);
            return;
        end
        e  = exp_q.pop_front();
        v0 = e.d[0];
        v1 = e.d[1];
        v2 = e.d[2];
        total++;
        if ({vld24, dat24, trm24, ovf24} !== {1'b1, v0[23:0], CW'(e.terms), e.o[0]})
            $display("FAIL %s acc24: got d=%h t=%0d o=%b, want d=%h t=%0d o=%b",
                     name, dat24, trm24, ovf24, v0[23:0], e.terms, e.o[0]);
        else passed++;
        total++;
        if ({vld16s, dat16s, trm16s, ovf16s} !== {1'b1, v1[15:0], CW'(e.terms), e.o[1]})
            $display("FAIL %s sat16: got d=%h t=%0d o=%b, want d=%h t=%0d o=%b",
                     name, dat16s, trm16s, ovf16s, v1[15:0], e.terms, e.o[1]);
        else passed++;
        total++;
        if ({vld16w, dat16w, trm16w, ovf16w} !== {1'b1, v2[15:0], CW'(e.terms), e.o[2]})
            $display("FAIL %s wrap16: got d=%h t=%0d o=%b, want d=%h t=%0d o=%b",
                     name, dat16w, trm16w, ovf16w, v2[15:0], e.terms, e.o[2]);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({vld24, rdy24, vld16s, rdy16s, vld16w, rdy16w} !== 6'b010101)
            $display("FAIL %s release: got valid/ready %b%b %b%b %b%b, want 01 01 01",
                     name, vld24, rdy24, vld16s, rdy16s, vld16w, rdy16w);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check_idle("reset");
    endtask

    task automatic test_basic_frame();
        beat(16'h0006, 1'b1, 1'b0, 1'b0);
        beat(16'hFFFA, 1'b1, 1'b0, 1'b0);
        total++;
        if (vld24 !== 1'b0) $display("FAIL basic early_valid: got %b, want 0", vld24);
        else passed++;
        beat(16'h0010, 1'b1, 1'b1, 1'b0);
        total++;
        if ({vld24, dat24, trm24} !== {1'b1, 24'h000010, 3'd3})
            $display("FAIL basic latency: got v=%b d=%h t=%0d, want v=1 d=000010 t=3", vld24, dat24, trm24);
        else passed++;
        expect_result("basic");
    endtask

    task automatic test_saturation();
        beat(16'h4000, 1'b1, 1'b0, 1'b0);
        beat(16'h4000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if ({dat16s, ovf16s, dat16w, ovf16w} !== {16'h7FFF, 1'b1, 16'h8000, 1'b1})
            $display("FAIL sat clamp_wrap: got sat=%h/%b wrap=%h/%b, want 7fff/1 8000/1",
                     dat16s, ovf16s, dat16w, ovf16w);
        else passed++;
        expect_result("saturate");
        beat(16'h0001, 1'b1, 1'b1, 1'b0);
        expect_result("after_saturate");
    endtask

    task automatic test_backpressure();
        logic [63:0] v0;
        beat(16'h0005, 1'b1, 1'b0, 1'b0);
        beat(16'h0123, 1'b1, 1'b1, 1'b0);
        v0 = exp_q[0].d[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            prod_in  = 16'h7777;
            in_valid = 1'b1;
            in_clr   = (k == 2);
            total++;
            if ({rdy24, vld24, dat24, trm24} !== {1'b0, 1'b1, v0[23:0], 3'd2})
                $display("FAIL backpressure hold%0d: got r=%b v=%b d=%h t=%0d, want r=0 v=1 d=%h t=2",
                         k, rdy24, vld24, dat24, trm24, v0[23:0]);
            else passed++;
        end
        in_valid = 1'b0;
        in_clr   = 1'b0;
        expect_result("backpressure");
    endtask

    task automatic test_forced_end();
        for (int k = 0; k < MAXT; k++) beat(16'h0001, 1'b1, 1'b0, 1'b0);
        expect_result("forced_end");
        beat(16'h0001, 1'b1, 1'b0, 1'b0);
        beat(16'h0002, 1'b1, 1'b1, 1'b0);
        expect_result("after_forced");
    endtask

    task automatic test_clear();
        beat(16'h0100, 1'b1, 1'b0, 1'b0);
        beat(16'h0200, 1'b1, 1'b0, 1'b0);
        beat(16'h0003, 1'b1, 1'b1, 1'b1);
        expect_result("clear_with_beat");
        beat(16'h7000, 1'b1, 1'b0, 1'b0);
        beat(16'h7000, 1'b1, 1'b0, 1'b0);
        beat(16'h0000, 1'b0, 1'b0, 1'b1);
        beat(16'h0007, 1'b1, 1'b1, 1'b0);
        expect_result("clear_alone");
    endtask

    task automatic test_reset_mid();
        beat(16'h0100, 1'b1, 1'b0, 1'b0);
        beat(16'h0200, 1'b1, 1'b0, 1'b0);
        apply_reset();
        check_idle("reset_mid_frame");
        beat(16'h0009, 1'b1, 1'b1, 1'b0);
        expect_result("after_mid_reset");
        beat(16'h0011, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        void'(exp_q.pop_back());
        apply_reset();
        check_idle("reset_in_done");
        beat(16'h0002, 1'b1, 1'b1, 1'b0);
        expect_result("after_done_reset");
    endtask

    task automatic test_back_to_back();
        int len;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, MAXT);
            for (int b = 0; b < len; b++)
                beat(16'($urandom_range(0, 65535)), 1'b1, (b == len - 1), 1'b0);
            expect_result($sformatf("random%0d", f));
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL leftover: got %0d pending frames, want 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_frame();
        test_saturation();
        test_backpressure();
        test_forced_end();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
